// File: rtl/wash_program_sequencer_if.sv
// Front-panel inputs and status/actuator outputs of the wash program sequencer.
// The program select is named prog_sel because "program" is a reserved word.
interface wash_program_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             tick;
  logic             start;
  logic [1:0]       prog_sel;
  logic             sig_Lid_Closed;
  logic             sig_Cancel;
  logic             sig_Fault;
  logic             sig_Fault_Clear;

  logic [2:0]       phase;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       rinse_count;
  logic             busy;
  logic             paused;
  logic             done;
  logic             fault;
  logic             valve_on;
  logic             heater_on;
  logic             motor_on;

  modport master (
    output tick, start, prog_sel, sig_Lid_Closed, sig_Cancel, sig_Fault, sig_Fault_Clear,
    input  phase, remaining, rinse_count, busy, paused, done, fault,
           valve_on, heater_on, motor_on
  );

  modport slave (
    input  tick, start, prog_sel, sig_Lid_Closed, sig_Cancel, sig_Fault, sig_Fault_Clear,
    output phase, remaining, rinse_count, busy, paused, done, fault,
           valve_on, heater_on, motor_on
  );
endinterface

// File: rtl/wash_program_sequencer.sv
// Wash program sequencer: latches a program on start and steps FILL/HEAT/WASH/RINSE/SPIN
// with tick-driven down-counters, handling lid pause, cancel and fault.
//
// state    | meaning
// IDLE  0  | waiting for start with lid closed
// FILL  1  | water intake (first fill or rinse fill)
// HEAT  2  | heating, heat programs only
// WASH  3  | main wash, doubled for heavy
// RINSE 4  | rinse agitation, repeats per program
// SPIN  5  | final spin, ends with done pulse
// FAULT 6  | actuators off until fault drops and is acknowledged
module wash_program_sequencer #(
  parameter int CNT_W       = 16,
  parameter int FILL_TICKS  = 4,
  parameter int HEAT_TICKS  = 3,
  parameter int WASH_TICKS  = 6,
  parameter int RINSE_TICKS = 5,
  parameter int SPIN_TICKS  = 4
) (
  input logic                    clock,
  input logic                    reset_n,
  wash_program_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_HEAT  = 3'd2,
    ST_WASH  = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LEN       = CNT_W'(FILL_TICKS);
  localparam logic [CNT_W-1:0] HEAT_LEN       = CNT_W'(HEAT_TICKS);
  localparam logic [CNT_W-1:0] WASH_LEN       = CNT_W'(WASH_TICKS);
  localparam logic [CNT_W-1:0] WASH_LEN_HEAVY = CNT_W'(2 * WASH_TICKS);
  localparam logic [CNT_W-1:0] RINSE_LEN      = CNT_W'(RINSE_TICKS);
  localparam logic [CNT_W-1:0] SPIN_LEN       = CNT_W'(SPIN_TICKS);

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       rinse_cnt_q;
  logic [1:0]       prog_q;
  logic             first_fill_q;
  logic             done_q;

  logic             running;
  logic             lid_open;
  logic             heat_en;
  logic [1:0]       rinse_target;
  logic [1:0]       rinse_next;
  logic [CNT_W-1:0] wash_len;

  always_comb begin
    running      = state_q inside {ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN};
    lid_open     = !bus.sig_Lid_Closed;
    rinse_next   = rinse_cnt_q + 2'd1;
    heat_en      = 1'b1;
    rinse_target = 2'd2;
    wash_len     = WASH_LEN;
    case (prog_q)
      2'd0: begin
        heat_en      = 1'b0;
        rinse_target = 2'd1;
      end
      2'd2: begin
        rinse_target = 2'd3;
        wash_len     = WASH_LEN_HEAVY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      rinse_cnt_q  <= '0;
      prog_q       <= '0;
      first_fill_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.sig_Fault && state_q != ST_FAULT) begin
        state_q <= ST_FAULT;
        rem_q   <= '0;
      end else if (state_q == ST_FAULT) begin
        if (bus.sig_Fault_Clear && !bus.sig_Fault)
          state_q <= ST_IDLE;
      end else if (running && bus.sig_Cancel) begin
        state_q <= ST_IDLE;
        rem_q   <= '0;
      end else if (running && lid_open) begin
        // paused: counter and state frozen so the resumed phase loses no ticks
      end else if (running && bus.tick) begin
        if (rem_q == CNT_W'(1)) begin
          case (state_q)
            ST_FILL: begin
              if (first_fill_q) begin
                first_fill_q <= 1'b0;
                if (heat_en) begin
                  state_q <= ST_HEAT;
                  rem_q   <= HEAT_LEN;
                end else begin
                  state_q <= ST_WASH;
                  rem_q   <= wash_len;
                end
              end else begin
                state_q <= ST_RINSE;
                rem_q   <= RINSE_LEN;
              end
            end
            ST_HEAT: begin
              state_q <= ST_WASH;
              rem_q   <= wash_len;
            end
            ST_WASH: begin
              state_q <= ST_FILL;
              rem_q   <= FILL_LEN;
            end
            ST_RINSE: begin
              rinse_cnt_q <= rinse_next;
              if (rinse_next < rinse_target) begin
                state_q <= ST_FILL;
                rem_q   <= FILL_LEN;
              end else begin
                state_q <= ST_SPIN;
                rem_q   <= SPIN_LEN;
              end
            end
            ST_SPIN: begin
              state_q <= ST_IDLE;
              rem_q   <= '0;
              done_q  <= 1'b1;
            end
            default: begin
              state_q <= ST_IDLE;
              rem_q   <= '0;
            end
          endcase
        end else begin
          rem_q <= rem_q - CNT_W'(1);
        end
      end else if (state_q == ST_IDLE && bus.start && bus.sig_Lid_Closed) begin
        state_q      <= ST_FILL;
        rem_q        <= FILL_LEN;
        rinse_cnt_q  <= '0;
        prog_q       <= bus.prog_sel;
        first_fill_q <= 1'b1;
      end
    end
  end

  assign bus.phase       = state_q;
  assign bus.remaining   = rem_q;
  assign bus.rinse_count = rinse_cnt_q;
  assign bus.busy        = running;
  assign bus.paused      = running && lid_open;
  assign bus.done        = done_q;
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.valve_on    = (state_q == ST_FILL) && !bus.paused;
  assign bus.heater_on   = (state_q == ST_HEAT) && !bus.paused;
  assign bus.motor_on    = (state_q inside {ST_WASH, ST_RINSE, ST_SPIN}) && !bus.paused;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer: per-cycle expectations queued at start and
// popped against the DUT each cycle, plus cancel, fault and async-reset scenarios.
module tb_wash_program_sequencer;
  localparam int CNT_W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  wash_program_sequencer_if #(.CNT_W(CNT_W)) bus ();

  wash_program_sequencer #(.CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]  phase;
    logic [15:0] rem;
    logic        paused;
    logic [2:0]  act;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {valve, heater, motor}
  function automatic logic [2:0] act_of(input logic [2:0] ph);
    return {ph == 3'd1, ph == 3'd2, (ph == 3'd3) || (ph == 3'd4) || (ph == 3'd5)};
  endfunction

  task automatic push_phase(input logic [2:0] ph, input int dur, input bit pause_at3);
    for (int r = dur; r >= 1; r--) begin
      sb_q.push_back('{phase: ph, rem: 16'(r), paused: 1'b0, act: act_of(ph)});
      if (pause_at3 && r == 3)
        repeat (7) sb_q.push_back('{phase: ph, rem: 16'(r), paused: 1'b1, act: 3'b000});
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input string tag);
    int k = 0;
    while (bus.phase !== ph && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(bus.phase), 32'(ph));
  endtask

  task automatic start_prog(input logic [1:0] prog);
    @(negedge clock);
    bus.prog_sel       = prog;
    bus.sig_Lid_Closed = 1'b1;
    bus.start          = 1'b1;
    @(negedge clock);
    bus.start    = 1'b0;
    bus.prog_sel = ~prog;
  endtask

  task automatic run_program(input logic [1:0] prog, input bit pause, input int exp_total);
    int heat, rinses, wash, n;
    exp_t e;
    case (prog)
      2'd0:    begin heat = 0; rinses = 1; wash = 6;  end
      2'd2:    begin heat = 1; rinses = 3; wash = 12; end
      default: begin heat = 1; rinses = 2; wash = 6;  end
    endcase
    sb_q.delete();
    push_phase(3'd1, 4, 1'b0);
    if (heat != 0) push_phase(3'd2, 3, 1'b0);
    push_phase(3'd3, wash, pause);
    repeat (rinses) begin
      push_phase(3'd1, 4, 1'b0);
      push_phase(3'd4, 5, 1'b0);
    end
    push_phase(3'd5, 4, 1'b0);

    start_prog(prog);
    n = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("phase",     32'(bus.phase),     32'(e.phase));
      chk("remaining", 32'(bus.remaining), 32'(e.rem));
      chk("paused",    32'(bus.paused),    32'(e.paused));
      chk("actuators", 32'({bus.valve_on, bus.heater_on, bus.motor_on}), 32'(e.act));
      chk("busy",      32'(bus.busy),      32'd1);
      chk("done_early", 32'(bus.done),     32'd0);
      n++;
      bus.sig_Lid_Closed = !(sb_q.size() > 0 && sb_q[0].paused);
      @(negedge clock);
    end
    chk("done",        32'(bus.done),        32'd1);
    chk("end_phase",   32'(bus.phase),       32'd0);
    chk("end_rem",     32'(bus.remaining),   32'd0);
    chk("rinse_count", 32'(bus.rinse_count), 32'(rinses));
    chk("run_length",  32'(n),               32'(exp_total));
    @(negedge clock);
    chk("done_pulse",  32'(bus.done),        32'd0);
    chk("rinse_hold",  32'(bus.rinse_count), 32'(rinses));
  endtask

  initial begin
    bus.tick            = 1'b1;
    bus.start           = 1'b0;
    bus.prog_sel        = 2'd0;
    bus.sig_Lid_Closed  = 1'b1;
    bus.sig_Cancel      = 1'b0;
    bus.sig_Fault       = 1'b0;
    bus.sig_Fault_Clear = 1'b0;

    #23;
    chk("rst_phase", 32'(bus.phase),     32'd0);
    chk("rst_rem",   32'(bus.remaining), 32'd0);
    chk("rst_rinse", 32'(bus.rinse_count), 32'd0);
    chk("rst_flags", 32'({bus.busy, bus.paused, bus.done, bus.fault,
                          bus.valve_on, bus.heater_on, bus.motor_on}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_program(2'd0, 1'b0, 23);
    run_program(2'd1, 1'b0, 35);
    run_program(2'd2, 1'b0, 50);
    run_program(2'd1, 1'b1, 42);

    // cancel during RINSE
    start_prog(2'd1);
    wait_phase(3'd4, "reach_rinse");
    bus.sig_Cancel = 1'b1;
    @(negedge clock);
    bus.sig_Cancel = 1'b0;
    chk("cancel_phase", 32'(bus.phase),     32'd0);
    chk("cancel_done",  32'(bus.done),      32'd0);
    chk("cancel_rem",   32'(bus.remaining), 32'd0);
    chk("cancel_act",   32'({bus.valve_on, bus.heater_on, bus.motor_on}), 32'd0);
    bus.sig_Lid_Closed = 1'b0;
    bus.start          = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("lid_open_start", 32'(bus.phase), 32'd0);
    @(negedge clock);
    chk("lid_open_start2", 32'(bus.phase), 32'd0);
    bus.sig_Lid_Closed = 1'b1;

    // fault during SPIN
    start_prog(2'd0);
    wait_phase(3'd5, "reach_spin");
    bus.sig_Fault = 1'b1;
    @(negedge clock);
    chk("fault_phase", 32'(bus.phase),     32'd6);
    chk("fault_flag",  32'(bus.fault),     32'd1);
    chk("fault_motor", 32'(bus.motor_on),  32'd0);
    chk("fault_rem",   32'(bus.remaining), 32'd0);
    bus.sig_Fault_Clear = 1'b1;
    @(negedge clock);
    chk("clear_ignored", 32'(bus.phase), 32'd6);
    bus.sig_Fault_Clear = 1'b0;
    bus.sig_Fault       = 1'b0;
    @(negedge clock);
    chk("fault_holds", 32'(bus.phase), 32'd6);
    bus.sig_Fault_Clear = 1'b1;
    @(negedge clock);
    bus.sig_Fault_Clear = 1'b0;
    chk("clear_phase", 32'(bus.phase), 32'd0);
    chk("clear_fault", 32'(bus.fault), 32'd0);

    // async reset mid-HEAT, between clock edges
    start_prog(2'd1);
    wait_phase(3'd2, "reach_heat");
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_phase", 32'(bus.phase),     32'd0);
    chk("areset_rem",   32'(bus.remaining), 32'd0);
    chk("areset_flags", 32'({bus.busy, bus.done, bus.fault,
                             bus.valve_on, bus.heater_on, bus.motor_on}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_program(2'd1, 1'b0, 35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
